// File: rtl/seg_scan_if.sv
// Signal bundle between a display scanner and the logic that feeds it digit codes.
// The scanner side is the slave; whoever supplies digits and watches the anodes is the master.
interface seg_scan_if;
    logic       enable;
    logic [3:0] led0;
    logic [3:0] led1;
    logic [3:0] led2;
    logic [3:0] led3;
    logic [3:0] led4;
    logic [3:0] led5;
    logic [3:0] led6;
    logic [3:0] led7;
    logic [7:0] dot_en;
    logic [7:0] blink_en;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output enable, led0, led1, led2, led3, led4, led5, led6, led7, dot_en, blink_en,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  enable, led0, led1, led2, led3, led4, led5, led6, led7, dot_en, blink_en,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Multiplexed 8-digit seven-segment scanner with per-digit decimal point and blink.
// Digit contents are captured at each frame start so a frame is never torn by input changes.
module seg_scan #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 2000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int unsigned CntW   = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [CntW-1:0]   CntMax   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]   BlankEnd = CntW'(BLANK_CYC);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [7:0][3:0]   code_q, code_d;
    logic [7:0]        dot_q, dot_d;
    logic [7:0]        blink_q, blink_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_start;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        frame_start = bus.enable && (cnt_q == '0) && (idx_q == 3'd0);

        // Decode from the next snapshot so a zero-length dark window still shows fresh contents.
        code_d  = code_q;
        dot_d   = dot_q;
        blink_d = blink_q;
        if (frame_start) begin
            code_d  = {bus.led7, bus.led6, bus.led5, bus.led4,
                       bus.led3, bus.led2, bus.led1, bus.led0};
            dot_d   = bus.dot_en;
            blink_d = bus.blink_en;
        end

        blink_cnt_d   = blink_cnt_q + BlinkW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        cnt_d = '0;
        idx_d = 3'd0;
        if (bus.enable) begin
            if (cnt_q == CntMax) begin
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
                idx_d = idx_q;
            end
        end

        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;
        if (bus.enable) begin
            frame_done_d = (idx_q == 3'd7) && (cnt_q == CntMax);
            if (cnt_q >= BlankEnd) begin
                an_d = ~(8'b1 << idx_q);
                if (!(blink_d[idx_q] && !blink_phase_q)) begin
                    seg_d = decode(code_d[idx_q]);
                    dp_d  = ~dot_d[idx_q];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            code_q        <= {8{4'd11}};
            dot_q         <= 8'h00;
            blink_q       <= 8'h00;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            code_q        <= code_d;
            dot_q         <= dot_d;
            blink_q       <= blink_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: decode table, directed corner sequences and random traffic
// compared cycle by cycle against an arithmetic model of the scan schedule.
module tb_seg_scan;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int BLINK_DIV = 64;
    localparam int FRAME     = 8 * SCAN_DIV;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic       en;
    logic [3:0] led_v [8];
    logic [7:0] dot_v;
    logic [7:0] blink_v;

    int n_pass = 0;
    int n_total = 0;

    // Model state: edges since reset release, consecutive enabled edges, captured frame.
    int t;
    int e;
    logic [3:0] m_code [8];
    logic [7:0] m_dot;
    logic [7:0] m_blink;
    vec_t vecs [16];

    seg_scan_if bus ();

    assign bus.enable   = en;
    assign bus.led0     = led_v[0];
    assign bus.led1     = led_v[1];
    assign bus.led2     = led_v[2];
    assign bus.led3     = led_v[3];
    assign bus.led4     = led_v[4];
    assign bus.led5     = led_v[5];
    assign bus.led6     = led_v[6];
    assign bus.led7     = led_v[7];
    assign bus.dot_en   = dot_v;
    assign bus.blink_en = blink_v;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        t = 0;
        e = 0;
        for (int k = 0; k < 8; k++) m_code[k] = 4'd11;
        m_dot   = 8'h00;
        m_blink = 8'h00;
    endtask

    // Called just after a rising edge; returns just after the next one with outputs checked.
    task automatic step();
        logic [7:0] ea;
        logic [6:0] es;
        logic ed, ef;
        int c, i;
        bit vis;
        ea = 8'hFF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
        if (en) begin
            if (e % FRAME == 0) begin
                for (int k = 0; k < 8; k++) m_code[k] = led_v[k];
                m_dot   = dot_v;
                m_blink = blink_v;
            end
            c   = e % SCAN_DIV;
            i   = (e / SCAN_DIV) % 8;
            vis = ((t / BLINK_DIV) % 2) == 0;
            if (c >= BLANK_CYC) begin
                ea = 8'hFF ^ (8'd1 << i);
                if (!(m_blink[i] && !vis)) begin
                    es = vecs[m_code[i]].seg;
                    ed = !m_dot[i];
                end
            end
            ef = (e % FRAME) == FRAME - 1;
            e++;
        end else begin
            e = 0;
        end
        t++;
        @(posedge clk);
        #1;
        chk("an", 32'(bus.an), 32'(ea));
        chk("seg", 32'(bus.seg), 32'(es));
        chk("dp", 32'(bus.dp), 32'(ed));
        chk("frame_done", 32'(bus.frame_done), 32'(ef));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must go dark without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_to(input int idx, input int c);
        int n;
        n = 0;
        while (!(en && ((e / SCAN_DIV) % 8) == idx && (e % SCAN_DIV) == c) && n < 2 * FRAME) begin
            step();
            n++;
        end
    endtask

    task automatic set_leds(input logic [3:0] l7, l6, l5, l4, l3, l2, l1, l0);
        led_v[7] = l7; led_v[6] = l6; led_v[5] = l5; led_v[4] = l4;
        led_v[3] = l3; led_v[2] = l2; led_v[1] = l1; led_v[0] = l0;
    endtask

    initial begin
        vecs[0]  = '{code: 4'd0,  seg: 7'b1000000};
        vecs[1]  = '{code: 4'd1,  seg: 7'b1111001};
        vecs[2]  = '{code: 4'd2,  seg: 7'b0100100};
        vecs[3]  = '{code: 4'd3,  seg: 7'b0110000};
        vecs[4]  = '{code: 4'd4,  seg: 7'b0011001};
        vecs[5]  = '{code: 4'd5,  seg: 7'b0010010};
        vecs[6]  = '{code: 4'd6,  seg: 7'b0000010};
        vecs[7]  = '{code: 4'd7,  seg: 7'b1111000};
        vecs[8]  = '{code: 4'd8,  seg: 7'b0000000};
        vecs[9]  = '{code: 4'd9,  seg: 7'b0010000};
        vecs[10] = '{code: 4'd10, seg: 7'b0111111};
        for (int k = 11; k < 16; k++) vecs[k] = '{code: 4'(k), seg: 7'b1111111};

        en = 1'b1;
        dot_v = 8'h00;
        blink_v = 8'h00;
        set_leds(4'd1, 4'd2, 4'd10, 4'd3, 4'd4, 4'd10, 4'd5, 4'd6);
        #2;
        do_reset();

        // Basic scan, two full frames plus change.
        steps(70);

        // A mid-frame change of led0 must wait for the next frame start.
        run_to(3, 0);
        led_v[0] = 4'd9;
        steps(40);

        // Blink on digit 0 and dot on digit 2 across the first blink off-phase.
        do_reset();
        blink_v = 8'h01;
        dot_v   = 8'h04;
        steps(200);

        // Enable drop part-way through the frame, then restart at digit 0.
        run_to(5, 1);
        en = 1'b0;
        steps(6);
        en = 1'b1;
        steps(40);

        // Reset in the middle of a slot.
        run_to(4, 2);
        do_reset();
        steps(12);

        // Blank codes on every digit.
        blink_v = 8'h00;
        dot_v   = 8'h00;
        set_leds(4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd11, 4'd12, 4'd15);
        steps(40);

        // Decode table: re-enable to force a frame start, then digit 0 is lit on the third edge.
        for (int v = 0; v < 16; v++) begin
            en = 1'b0;
            step();
            for (int k = 0; k < 8; k++) led_v[k] = vecs[v].code;
            en = 1'b1;
            step();
            step();
            chk("decode", 32'(bus.seg), 32'(vecs[v].seg));
            step();
            step();
        end

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) led_v[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) dot_v = 8'($urandom);
            if ($urandom_range(0, 39) == 0) blink_v = 8'($urandom);
            if ($urandom_range(0, 59) == 0) en = ~en;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
